// File: rtl/truth_table_seq.sv
// Truth-table sweeper: drives {a,b} through all four vectors, holds each for HOLD_CYCLES,
// samples y_in on the last hold cycle and accumulates sticky mismatch flags. Macro TTSEQ_GRAY_ORDER_EN selects Gray order.
module truth_table_seq #(
  parameter int                   HOLD_CYCLES = 10,
  parameter int                   NUM_OUT     = 4,
  parameter logic [4*NUM_OUT-1:0] EXP_VEC     = 16'h3EE8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [NUM_OUT-1:0] y_in,
  output logic               a,
  output logic               b,
  output logic [1:0]         vec_idx,
  output logic               busy,
  output logic               done,
  output logic [NUM_OUT-1:0] mismatch,
  output logic               pass
);

  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_FINISH} state_t;

  localparam logic [7:0] LAST_CNT = 8'(HOLD_CYCLES - 1);

  state_t             state_q, state_d;
  logic [7:0]         cnt_q, cnt_d;
  logic [1:0]         step_q, step_d;
  logic [1:0]         vec_q, vec_d;
  logic [NUM_OUT-1:0] mism_q, mism_d;
  logic               pass_q, pass_d;

  // Application order is a function of the step count; lookup always uses the applied {a,b}.
  function automatic logic [1:0] step_to_vec(input logic [1:0] s);
`ifdef TTSEQ_GRAY_ORDER_EN
    return {s[1], s[1] ^ s[0]};
`else
    return s;
`endif
  endfunction

  function automatic logic [NUM_OUT-1:0] exp_of(input logic [1:0] idx);
    return EXP_VEC[int'(idx)*NUM_OUT +: NUM_OUT];
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      step_q  <= '0;
      vec_q   <= '0;
      mism_q  <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      step_q  <= step_d;
      vec_q   <= vec_d;
      mism_q  <= mism_d;
      pass_q  <= pass_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    step_d  = step_q;
    vec_d   = vec_q;
    mism_d  = mism_q;
    pass_d  = pass_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_DRIVE;
          cnt_d   = '0;
          step_d  = '0;
          vec_d   = step_to_vec(2'd0);
          mism_d  = '0;
          pass_d  = 1'b0;
        end
      end
      S_DRIVE: begin
        if (cnt_q == LAST_CNT) begin
          mism_d = mism_q | (y_in ^ exp_of(vec_q));
          if (step_q == 2'd3) begin
            // pass reflects the final sample as well, so it is valid alongside done.
            state_d = S_FINISH;
            pass_d  = ~|mism_d;
          end else begin
            step_d = step_q + 2'd1;
            vec_d  = step_to_vec(step_d);
            cnt_d  = '0;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy     = (state_q == S_DRIVE);
    done     = (state_q == S_FINISH);
    a        = vec_q[1];
    b        = vec_q[0];
    vec_idx  = vec_q;
    mismatch = mism_q;
    pass     = pass_q;
  end

endmodule

// File: tb/tb_truth_table_seq.sv
// Directed bench for truth_table_seq: gate-level DUT model on y_in, default and HOLD_CYCLES=2 instances.
module tb_truth_table_seq;

  logic       clk = 1'b0;
  logic       rst_n, start, start2, xor_kill;
  logic       a1, b1, busy1, done1, pass1;
  logic [1:0] vec1;
  logic [3:0] mis1, y1;
  logic       a2, b2, busy2, done2, pass2;
  logic [1:0] vec2;
  logic [3:0] mis2, y2;

  int n_cmp = 0;
  int n_mis = 0;
  int exp_order[4];

  always #5 clk = ~clk;

  // Correct AND/OR/XOR/NAND gates, XOR optionally stuck at 0.
  assign y1 = {~(a1 & b1), (a1 ^ b1) & ~xor_kill, a1 | b1, a1 & b1};
  assign y2 = {~(a2 & b2), a2 ^ b2, a2 | b2, a2 & b2};

  truth_table_seq u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .y_in(y1),
    .a(a1), .b(b1), .vec_idx(vec1), .busy(busy1), .done(done1),
    .mismatch(mis1), .pass(pass1)
  );

  truth_table_seq #(.HOLD_CYCLES(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .y_in(y2),
    .a(a2), .b(b2), .vec_idx(vec2), .busy(busy2), .done(done2),
    .mismatch(mis2), .pass(pass2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic run_sweep(input logic [3:0] exp_mis, input logic exp_pass, input bit repulse);
    int cyc;
    int done_cyc;
    int extra_done;
    done_cyc   = -1;
    extra_done = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc   = 1;
    chk("busy_after_accept", busy1, 1'b1);
    while (done_cyc < 0 && cyc <= 100) begin
      for (int k = 0; k < 4; k++) begin
        if (cyc == 10*k + 1)  chk("vec_first", vec1, exp_order[k]);
        if (cyc == 10*k + 10) chk("vec_last", vec1, exp_order[k]);
      end
      if (cyc == 20) chk("mis_before_v01_sample", mis1, 4'b0000);
      if (cyc == 21) chk("mis_after_v01_sample", mis1, exp_mis);
      if (repulse && cyc == 15) start = 1'b1;
      if (repulse && cyc == 16) start = 1'b0;
      if (done1) done_cyc = cyc;
      else begin
        @(negedge clk);
        cyc++;
      end
    end
    chk("done_latency", done_cyc, 41);
    chk("pass_at_done", pass1, exp_pass);
    chk("mismatch_at_done", mis1, exp_mis);
    chk("busy_at_done", busy1, 1'b0);
    if (repulse) start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("done_one_cycle", done1, 1'b0);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done1 || busy1) extra_done++;
    end
    chk("no_extra_sweep", extra_done, 0);
    chk("pass_held_idle", pass1, exp_pass);
  endtask

  initial begin
    int cyc;
    int cnt;
`ifdef TTSEQ_GRAY_ORDER_EN
    exp_order = '{0, 1, 3, 2};
`else
    exp_order = '{0, 1, 2, 3};
`endif
    rst_n    = 1'b0;
    start    = 1'b0;
    start2   = 1'b0;
    xor_kill = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy1, 1'b0);
    chk("rst_done", done1, 1'b0);
    chk("rst_ab", {a1, b1}, 2'b00);
    chk("rst_vec", vec1, 2'd0);
    chk("rst_mismatch", mis1, 4'b0000);
    chk("rst_pass", pass1, 1'b0);
    rst_n = 1'b1;

    // Clean sweep with correct gates.
    run_sweep(4'b0000, 1'b1, 1'b0);

    // XOR output stuck at 0.
    xor_kill = 1'b1;
    run_sweep(4'b0100, 1'b0, 1'b0);
    xor_kill = 1'b0;
    chk("mismatch_held_idle", mis1, 4'b0100);

    // Reset in the middle of vector 10.
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cnt   = 0;
    while (vec1 != 2'd2 && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    chk("reached_vec10", vec1, 2'd2);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", busy1, 1'b0);
    chk("abort_ab", {a1, b1}, 2'b00);
    chk("abort_done", done1, 1'b0);
    chk("abort_mismatch", mis1, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;
    cnt   = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done1 || busy1) cnt++;
    end
    chk("no_done_after_abort", cnt, 0);
    run_sweep(4'b0000, 1'b1, 1'b0);

    // start re-pulsed during DRIVE and on the done cycle.
    run_sweep(4'b0000, 1'b1, 1'b1);

    // Short hold instance.
    @(negedge clk);
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    cyc    = 1;
    cnt    = -1;
    while (cnt < 0 && cyc <= 50) begin
      for (int k = 0; k < 4; k++) begin
        if (cyc == 2*k + 1) chk("h2_vec_first", vec2, exp_order[k]);
        if (cyc == 2*k + 2) chk("h2_vec_last", vec2, exp_order[k]);
      end
      if (done2) cnt = cyc;
      else begin
        @(negedge clk);
        cyc++;
      end
    end
    chk("h2_done_latency", cnt, 9);
    chk("h2_pass", pass2, 1'b1);
    chk("h2_mismatch", mis2, 4'b0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
